// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter: ROR/ROL/SRL/SLL/SRA with one registered stage per
// shift-amount bit and valid/ready handshaking on both sides.
module pipe_barrel_shifter #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [AMT_W-1:0] amt_i,
  input  logic [2:0]       op_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] y_o,
  output logic             zero_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  localparam logic [2:0] OpRor = 3'b000;
  localparam logic [2:0] OpRol = 3'b001;
  localparam logic [2:0] OpSrl = 3'b010;
  localparam logic [2:0] OpSll = 3'b011;
  localparam logic [2:0] OpSra = 3'b100;

  // Applies one fixed power-of-two shift; reserved ops pass data through.
  function automatic logic [WIDTH-1:0] shift_pow2(input logic [WIDTH-1:0] d,
                                                  input logic [2:0]       op,
                                                  input int unsigned      sh);
    logic [WIDTH-1:0] r;
    case (op)
      OpRor:   r = (d >> sh) | (d << (WIDTH - sh));
      OpRol:   r = (d << sh) | (d >> (WIDTH - sh));
      OpSrl:   r = d >> sh;
      OpSll:   r = d << sh;
      OpSra:   r = $signed(d) >>> sh;
      default: r = d;
    endcase
    return r;
  endfunction

  // Stage k consumes bit 0 of its amount and forwards the amount shifted right by one.
  logic [AMT_W-1:0][WIDTH-1:0] data_q, data_d;
  logic [AMT_W-2:0][AMT_W-1:0] amt_q, amt_d;
  logic [AMT_W-2:0][2:0]       op_q, op_d;
  logic [AMT_W-1:0]            valid_q;

  logic [AMT_W-1:0][WIDTH-1:0] st_data;
  logic [AMT_W-1:0][AMT_W-1:0] st_amt;
  logic [AMT_W-1:0][2:0]       st_op;
  logic [AMT_W-1:0]            st_vld;

  logic stall;
  logic unused_amt;

  assign stall       = valid_q[AMT_W-1] && !out_ready_i;
  assign in_ready_o  = !stall;
  assign y_o         = data_q[AMT_W-1];
  assign out_valid_o = valid_q[AMT_W-1];
  assign zero_o      = valid_q[AMT_W-1] && (data_q[AMT_W-1] == '0);
  assign unused_amt  = ^st_amt[AMT_W-1][AMT_W-1:1];

  always_comb begin
    st_data    = '0;
    st_amt     = '0;
    st_op      = '0;
    st_vld     = '0;
    data_d     = '0;
    amt_d      = '0;
    op_d       = '0;
    st_data[0] = a_i;
    st_amt[0]  = amt_i;
    st_op[0]   = op_i;
    st_vld[0]  = in_valid_i;
    for (int unsigned k = 1; k < AMT_W; k++) begin
      st_data[k] = data_q[k-1];
      st_amt[k]  = amt_q[k-1];
      st_op[k]   = op_q[k-1];
      st_vld[k]  = valid_q[k-1];
    end
    for (int unsigned k = 0; k < AMT_W; k++) begin
      data_d[k] = st_amt[k][0] ? shift_pow2(st_data[k], st_op[k], 32'd1 << k) : st_data[k];
    end
    for (int unsigned k = 0; k < AMT_W - 1; k++) begin
      amt_d[k] = st_amt[k] >> 1;
      op_d[k]  = st_op[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      amt_q   <= '0;
      op_q    <= '0;
      valid_q <= '0;
    end else if (!stall) begin
      data_q  <= data_d;
      amt_q   <= amt_d;
      op_q    <= op_d;
      valid_q <= st_vld;
    end
  end

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Self-checking bench for pipe_barrel_shifter at WIDTH=8: vector table, corner
// sequences and randomized traffic against a bit-level reference model.
module tb_pipe_barrel_shifter;

  localparam int W   = 8;
  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic [W-1:0] a_i = '0;
  logic [2:0]   amt_i = '0;
  logic [2:0]   op_i = '0;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  logic [W-1:0] y_o;
  logic         zero_o;
  logic         out_valid_o;
  logic         out_ready_i = 1'b1;

  pipe_barrel_shifter #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .a_i        (a_i),
    .amt_i      (amt_i),
    .op_i       (op_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .y_o        (y_o),
    .zero_o     (zero_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: each output bit picked from the operand by index arithmetic.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] a, input int amt,
                                            input logic [2:0] op);
    logic [W-1:0] y;
    for (int i = 0; i < W; i++) begin
      case (op)
        3'd0:    y[i] = a[(i + amt) % W];
        3'd1:    y[i] = a[(i - amt + W) % W];
        3'd2:    y[i] = (i + amt < W) ? a[i + amt] : 1'b0;
        3'd3:    y[i] = (i >= amt) ? a[i - amt] : 1'b0;
        3'd4:    y[i] = (i + amt < W) ? a[i + amt] : a[W-1];
        default: y[i] = a[i];
      endcase
    end
    return y;
  endfunction

  typedef struct {
    logic [W-1:0] exp;
    int           acc_cyc;
    int           acc_stall;
  } sb_t;

  sb_t          sbq[$];
  logic [W-1:0] exp_in = '0;
  int           cyc = 0;
  int           stall_cnt = 0;
  int           n_out = 0;

  // Monitor/scoreboard, sampling on the falling edge.
  initial begin
    logic         prev_stall;
    logic [W-1:0] prev_y;
    logic         stall;
    sb_t          e;
    prev_stall = 1'b0;
    prev_y     = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_i) begin
        sbq.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 32'(out_valid_o), 32'd1);
          chk("hold_y", 32'(y_o), 32'(prev_y));
        end
        stall = out_valid_o && !out_ready_i;
        chk("in_ready", 32'(in_ready_o), 32'(!stall));
        if (out_valid_o && out_ready_i) begin
          if (sbq.size() == 0) begin
            chk("unexpected_out", 32'(out_valid_o), 32'd0);
          end else begin
            e = sbq.pop_front();
            chk("y", 32'(y_o), 32'(e.exp));
            chk("zero", 32'(zero_o), 32'(e.exp == '0));
            chk("latency", 32'(cyc - e.acc_cyc), 32'(LAT + stall_cnt - e.acc_stall));
            n_out++;
          end
        end
        if (in_valid_i && in_ready_o) sbq.push_back('{exp_in, cyc, stall_cnt});
        if (stall) stall_cnt++;
        prev_stall = stall;
        prev_y     = y_o;
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [2:0] amt, input logic [2:0] op,
                      input logic [W-1:0] exp);
    bit ok;
    a_i = a; amt_i = amt; op_i = op; exp_in = exp; in_valid_i = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 32'(in_ready_o), 32'd1);
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic send_rand(input logic [W-1:0] a, input logic [2:0] amt, input logic [2:0] op);
    send(a, amt, op, ref_shift(a, int'(amt), op));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !out_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 32'(sbq.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [2:0]   amt;
    logic [2:0]   op;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[13];
  bit   done = 1'b0;

  initial begin
    int base;
    vecs[0]  = '{8'hB2, 3'd3, 3'd0, 8'h56};
    vecs[1]  = '{8'hB2, 3'd3, 3'd1, 8'h95};
    vecs[2]  = '{8'hB2, 3'd3, 3'd2, 8'h16};
    vecs[3]  = '{8'hB2, 3'd3, 3'd3, 8'h90};
    vecs[4]  = '{8'hB2, 3'd3, 3'd4, 8'hF6};
    vecs[5]  = '{8'hB2, 3'd0, 3'd0, 8'hB2};
    vecs[6]  = '{8'hB2, 3'd0, 3'd1, 8'hB2};
    vecs[7]  = '{8'hB2, 3'd0, 3'd2, 8'hB2};
    vecs[8]  = '{8'hB2, 3'd0, 3'd3, 8'hB2};
    vecs[9]  = '{8'hB2, 3'd0, 3'd4, 8'hB2};
    vecs[10] = '{8'hB2, 3'd0, 3'd7, 8'hB2};
    vecs[11] = '{8'h80, 3'd7, 3'd2, 8'h01};
    vecs[12] = '{8'h01, 3'd1, 3'd2, 8'h00};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_zero", 32'(zero_o), 32'd0);
    chk("rst_y", 32'(y_o), 32'd0);
    chk("rst_in_ready", 32'(in_ready_o), 32'd1);
    @(posedge clk);
    #1;

    // Vector table, one beat at a time
    for (int i = 0; i < 13; i++) begin
      send(vecs[i].a, vecs[i].amt, vecs[i].op, vecs[i].exp);
      drain();
    end

    // Back-to-back ROR stream
    base = n_out;
    for (int k = 0; k < 8; k++) send_rand(8'h01, 3'(k), 3'd0);
    drain();
    chk("stream_count", 32'(n_out - base), 32'd8);

    // Backpressure
    base = n_out;
    for (int k = 0; k < 4; k++) send_rand(8'(8'h3C + k * 17), 3'(k + 1), 3'(k));
    out_ready_i = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready_o), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready_i = 1'b1;
    drain();
    chk("bp_count", 32'(n_out - base), 32'd4);

    // Reset mid-flight
    base = n_out;
    send_rand(8'hA5, 3'd2, 3'd0);
    send_rand(8'h5A, 3'd5, 3'd3);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid_o), 32'd0);
    chk("midrst_in_ready", 32'(in_ready_o), 32'd1);
    idle(6);
    chk("midrst_no_out", 32'(n_out - base), 32'd0);
    send(8'h0F, 3'd4, 3'd3, 8'hF0);
    drain();
    chk("midrst_new", 32'(n_out - base), 32'd1);

    // Bubbles
    base = n_out;
    for (int k = 0; k < 8; k++) begin
      send_rand(8'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 4)));
      idle(1);
    end
    drain();
    chk("bubble_count", 32'(n_out - base), 32'd8);

    // Random traffic with random backpressure
    base = n_out;
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          send_rand(8'($urandom), 3'($urandom), 3'($urandom));
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready_i = 1'b1;
    drain();
    chk("rand_count", 32'(n_out - base), 32'd300);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
